// File: rtl/elevator_request_dispatcher.sv
// rtl/elevator_request_dispatcher.sv - SCAN floor-call dispatcher with door dwell timer; optional EMERGENCY_RECALL_EN adds RECALL
module elevator_request_dispatcher #(
    parameter int NUM_FLOORS   = 5,
    parameter int FLOOR_W      = 3,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  CLK,        // system clock, rising edge
    input  logic                  RESET,      // synchronous, active-high
    input  logic [NUM_FLOORS-1:0] BTN,        // call buttons, bit i = floor i
    input  logic [FLOOR_W-1:0]    CUR_FLOOR,  // car position from the controller
`ifdef EMERGENCY_RECALL_EN
    input  logic                  RECALL,     // emergency recall to ground floor
`endif
    output logic [FLOOR_W-1:0]    DTF,        // destination floor to the controller
    output logic                  UPDN,       // 1 = up, 0 = down
    output logic                  REQ_VALID,  // DTF/UPDN command motion
    output logic                  DOOR_OPEN,  // door dwell in progress
    output logic [NUM_FLOORS-1:0] PENDING,    // latched outstanding calls
    output logic                  BUSY        // not idle
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [FLOOR_W:0]   NF_EXT   = (FLOOR_W + 1)'(NUM_FLOORS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVE_UP = 2'd1,
        S_MOVE_DN = 2'd2,
        S_DWELL   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]      dtf_q, dtf_d;
    logic                    updn_q, updn_d;
    logic                    req_valid_q, req_valid_d;
    logic                    door_open_q, door_open_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    in_range;
    logic [NUM_FLOORS-1:0]   cur_onehot;
    logic                    has_above, has_below;
    logic [FLOOR_W-1:0]      above_fl, below_fl;
    logic [FLOOR_W-1:0]      dist_up, dist_dn;
    logic                    take_up;
    logic                    stopped;
    logic                    same_floor_press;
    logic [NUM_FLOORS-1:0]   set_mask, clr_mask;

    assign in_range   = ({1'b0, CUR_FLOOR} < NF_EXT);
    assign cur_onehot = in_range ? (NUM_FLOORS'(1) << CUR_FLOOR) : '0;

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        has_above = 1'b0;
        above_fl  = '0;
        has_below = 1'b0;
        below_fl  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W'(i) > CUR_FLOOR) && !has_above) begin
                has_above = 1'b1;
                above_fl  = FLOOR_W'(i);
            end
            if (pending_q[i] && (FLOOR_W'(i) < CUR_FLOOR)) begin
                has_below = 1'b1;
                below_fl  = FLOOR_W'(i);
            end
        end
    end

    assign dist_up = above_fl - CUR_FLOOR;
    assign dist_dn = CUR_FLOOR - below_fl;
    // Equal distances resolve upward.
    assign take_up = has_above && (!has_below || (dist_up <= dist_dn));

    // A press at the floor where the car stands reopens the door instead of
    // becoming a call.
    assign stopped          = (state_q == S_IDLE) || (state_q == S_DWELL);
    assign same_floor_press = stopped && |(BTN & cur_onehot);
    assign set_mask         = stopped ? (BTN & ~cur_onehot) : BTN;

    always_comb begin
        state_d  = state_q;
        dtf_d    = dtf_q;
        updn_d   = updn_q;
        cnt_d    = cnt_q;
        clr_mask = '0;

        // Out-of-range car position freezes sequencing; calls still latch.
        if (in_range) begin
            case (state_q)
                S_IDLE: begin
                    if (same_floor_press || |(pending_q & cur_onehot)) begin
                        state_d  = S_DWELL;
                        cnt_d    = CNT_LOAD;
                        clr_mask = cur_onehot;
                    end else if (take_up) begin
                        state_d = S_MOVE_UP;
                        dtf_d   = above_fl;
                        updn_d  = 1'b1;
                    end else if (has_below) begin
                        state_d = S_MOVE_DN;
                        dtf_d   = below_fl;
                        updn_d  = 1'b0;
                    end
                end
                S_MOVE_UP, S_MOVE_DN: begin
                    if (CUR_FLOOR == dtf_q) begin
                        state_d  = S_DWELL;
                        cnt_d    = CNT_LOAD;
                        clr_mask = cur_onehot;
                    end else if ((state_q == S_MOVE_UP) && has_above) begin
                        dtf_d = above_fl;
                    end else if ((state_q == S_MOVE_DN) && has_below) begin
                        dtf_d = below_fl;
                    end
                end
                S_DWELL: begin
                    if (same_floor_press) begin
                        cnt_d = CNT_LOAD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (updn_q ? has_above : !has_below && has_above) begin
                        state_d = S_MOVE_UP;
                        dtf_d   = above_fl;
                        updn_d  = 1'b1;
                    end else if (has_below) begin
                        state_d = S_MOVE_DN;
                        dtf_d   = below_fl;
                        updn_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Clear beats set when both hit the same bit in one cycle.
        pending_d   = (pending_q | set_mask) & ~clr_mask;
        req_valid_d = in_range && ((state_d == S_MOVE_UP) || (state_d == S_MOVE_DN));
        door_open_d = in_range && (state_d == S_DWELL);
        busy_d      = (state_d != S_IDLE);

`ifdef EMERGENCY_RECALL_EN
        // Recall overrides everything: run down to ground and hold the door.
        // Parking the FSM in IDLE makes release resume with the door closed.
        if (RECALL) begin
            state_d     = S_IDLE;
            pending_d   = '0;
            dtf_d       = '0;
            updn_d      = 1'b0;
            cnt_d       = '0;
            req_valid_d = in_range && (CUR_FLOOR != '0);
            door_open_d = in_range && (CUR_FLOOR == '0);
            busy_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            dtf_q       <= '0;
            updn_q      <= 1'b1;
            req_valid_q <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            dtf_q       <= dtf_d;
            updn_q      <= updn_d;
            req_valid_q <= req_valid_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign DTF       = dtf_q;
    assign UPDN      = updn_q;
    assign REQ_VALID = req_valid_q;
    assign DOOR_OPEN = door_open_q;
    assign PENDING   = pending_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_elevator_request_dispatcher.sv
// tb/tb_elevator_request_dispatcher.sv - directed self-checking bench for elevator_request_dispatcher
module tb_elevator_request_dispatcher;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [4:0] BTN = '0;
    logic [2:0] CUR_FLOOR = '0;
`ifdef EMERGENCY_RECALL_EN
    logic       RECALL = 1'b0;
`endif
    logic [2:0] DTF;
    logic       UPDN;
    logic       REQ_VALID;
    logic       DOOR_OPEN;
    logic [4:0] PENDING;
    logic       BUSY;

    logic [11:0] obs;
    logic [11:0] exp;
    int          vectors = 0;
    int          miscompares = 0;

    // obs = {BUSY, REQ_VALID, DOOR_OPEN, UPDN, DTF[2:0], PENDING[4:0]}
    assign obs = {BUSY, REQ_VALID, DOOR_OPEN, UPDN, DTF, PENDING};

    always #5 CLK = ~CLK;

    elevator_request_dispatcher #(
        .NUM_FLOORS  (5),
        .FLOOR_W     (3),
        .DWELL_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN      (BTN),
        .CUR_FLOOR(CUR_FLOOR),
`ifdef EMERGENCY_RECALL_EN
        .RECALL   (RECALL),
`endif
        .DTF      (DTF),
        .UPDN     (UPDN),
        .REQ_VALID(REQ_VALID),
        .DOOR_OPEN(DOOR_OPEN),
        .PENDING  (PENDING),
        .BUSY     (BUSY)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] floor);
        RESET = 1'b1;
        BTN = '0;
        CUR_FLOOR = floor;
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd0);
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL reset_values obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_basic();
        do_reset(3'd0);
        BTN = 5'b00100; step();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00100};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL basic_latch obs=%b expected=%b", obs, exp); end
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 5'b00100};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL basic_move obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd1; step();
        CUR_FLOOR = 3'd2; step();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL basic_arrive obs=%b expected=%b", obs, exp); end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (DOOR_OPEN !== 1'b1) begin miscompares++; $display("FAIL basic_dwell%0d door=%b expected=1", k, DOOR_OPEN); end
        end
        step();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL basic_idle obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_en_route();
        do_reset(3'd0);
        BTN = 5'b10000; step();
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 5'b10000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL enroute_start obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd1; step();
        BTN = 5'b00100; step();
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 5'b10100};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL enroute_retarget obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd2; step();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'b10000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL enroute_stop obs=%b expected=%b", obs, exp); end
        for (int k = 0; k < 4; k++) step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 5'b10000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL enroute_resume obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_reversal();
        do_reset(3'd2);
        BTN = 5'b10001; step();
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 5'b10001};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rev_tie_up obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd3; step();
        CUR_FLOOR = 3'd4; step();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00001};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rev_top_stop obs=%b expected=%b", obs, exp); end
        for (int k = 0; k < 4; k++) step();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00001};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rev_turn_down obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd2; step();
        CUR_FLOOR = 3'd0; step();
        for (int k = 0; k < 4; k++) step();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rev_idle_gnd obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_tie();
        do_reset(3'd2);
        BTN = 5'b01010; step();
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 5'b01010};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL tie_up obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_dwell_restart();
        do_reset(3'd2);
        BTN = 5'b00100; step();
        BTN = '0;
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restart_open obs=%b expected=%b", obs, exp); end
        step();
        step();
        BTN = 5'b00100; step();
        BTN = '0;
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restart_press obs=%b expected=%b", obs, exp); end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (DOOR_OPEN !== 1'b1) begin miscompares++; $display("FAIL restart_hold%0d door=%b expected=1", k, DOOR_OPEN); end
        end
        step();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restart_close obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_out_of_range();
        do_reset(3'd0);
        BTN = 5'b01000; step();
        BTN = '0; step();
        CUR_FLOOR = 3'd7; BTN = 5'b00010; step();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 5'b01010};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL oor_freeze obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd1; BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 5'b01010};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL oor_resume obs=%b expected=%b", obs, exp); end
    endtask

    task automatic test_reset_mid_motion();
        do_reset(3'd4);
        BTN = 5'b00011; step();
        BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'b00011};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL mid_move_dn obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd3; BTN = 5'b10000; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'b10011};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL mid_latch obs=%b expected=%b", obs, exp); end
        RESET = 1'b1; BTN = '0; step();
        RESET = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL mid_reset obs=%b expected=%b", obs, exp); end
    endtask

`ifdef EMERGENCY_RECALL_EN
    task automatic test_recall();
        do_reset(3'd3);
        BTN = 5'b10000; step();
        RECALL = 1'b1; BTN = '0; step();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL recall_start obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd1; BTN = 5'b00100; step();
        BTN = '0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL recall_ignore_btn obs=%b expected=%b", obs, exp); end
        CUR_FLOOR = 3'd0; step();
        step();
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL recall_door obs=%b expected=%b", obs, exp); end
        RECALL = 1'b0; step();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL recall_release obs=%b expected=%b", obs, exp); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_en_route();
        test_reversal();
        test_tie();
        test_dwell_restart();
        test_out_of_range();
        test_reset_mid_motion();
`ifdef EMERGENCY_RECALL_EN
        test_recall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
